window_line_buffer: RTL

Parametrised sliding-window generator for the streaming edge pipeline. It generalises the 1-bit 3x3 binary line buffer to any pixel width and any odd window size, with a runtime line width and start-of-frame resynchronisation. It sits between a pixel source (grey, Sobel magnitude or binary edge map) and any WINxWIN kernel stage, such as morphology, Sobel or filtering.

---
 rtl/window_line_buffer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/window_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : window_line_buffer
// Brief    : Streaming WINxWIN sliding-window generator with WIN-1 line RAMs,
//            runtime line width and start-of-frame resynchronisation.
// Revision : 1.0 - initial release
// ============================================================================
module window_line_buffer #(
  parameter int DATA_W    = 1,
  parameter int WIN       = 3,
  parameter int MAX_WIDTH = 640,
  parameter int AW        = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pixel_valid,
  input  logic [DATA_W-1:0]          pixel_in,
  input  logic                       sof,
  input  logic [AW:0]                cfg_width,
  output logic                       window_valid,
  output logic [WIN*WIN*DATA_W-1:0]  window_out,
  output logic                       line_done,
  output logic                       busy
);

  localparam int             c_row_w     = $clog2(WIN);
  localparam int             c_nram      = WIN - 1;
  localparam logic [AW:0]    c_max_width = (AW+1)'(MAX_WIDTH);
  localparam logic [AW:0]    c_win       = (AW+1)'(WIN);
  localparam logic [AW:0]    c_one       = (AW+1)'(1);
  localparam logic [AW-1:0]  c_win_col   = AW'(WIN - 1);
  localparam logic [c_row_w-1:0] c_row_max = c_row_w'(WIN - 1);
  localparam logic [c_row_w-1:0] c_row_one = c_row_w'(1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AW-1:0]        r_col;
  logic [c_row_w-1:0]   r_row;
  logic [AW:0]          r_width;

  logic                 w_accept;
  logic [AW:0]          w_width_cfg;
  logic [AW:0]          w_width_eff;
  logic [AW-1:0]        w_col_cur;
  logic [c_row_w-1:0]   w_row_cur;
  logic                 w_last;
  logic                 w_win_ok;

  logic [DATA_W-1:0]    r_line [c_nram][MAX_WIDTH];
  logic [DATA_W-1:0]    w_rd   [c_nram];
  logic [DATA_W-1:0]    w_newcol [WIN];
  logic [DATA_W-1:0]    r_win  [WIN][WIN];

  // A sof pixel is taken even in IDLE; it starts the frame as (0,0).
  assign w_accept    = pixel_valid & ((r_state == S_ACTIVE) | sof);
  assign w_width_cfg = ((cfg_width < c_win) || (cfg_width > c_max_width)) ? c_max_width : cfg_width;
  assign w_width_eff = sof ? w_width_cfg : r_width;
  assign w_col_cur   = sof ? '0 : r_col;
  assign w_row_cur   = sof ? '0 : r_row;
  assign w_last      = ({1'b0, w_col_cur} == (w_width_eff - c_one));
  assign w_win_ok    = (w_row_cur >= c_row_max) && (w_col_cur >= c_win_col);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and busy flag: leave IDLE only on an accepted sof, never return
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state == S_ACTIVE);
    if ((r_state == S_IDLE) && pixel_valid && sof) w_state_nxt = S_ACTIVE;
  end

  // Column/row counters and width latch; sof overrides any wrap on its pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_width <= c_max_width;
    end else if (w_accept) begin
      if (sof) r_width <= w_width_cfg;
      if (w_last) begin
        r_col <= '0;
        r_row <= (w_row_cur == c_row_max) ? w_row_cur : w_row_cur + c_row_one;
      end else begin
        r_col <= w_col_cur + AW'(1);
        r_row <= w_row_cur;
      end
    end
  end

  // Registered pulses, aligned with the window register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_valid <= 1'b0;
      line_done    <= 1'b0;
    end else begin
      window_valid <= w_accept & w_win_ok;
      line_done    <= w_accept & w_last;
    end
  end

  // Line RAM chain: asynchronous read gives old data on same-cycle write
  for (genvar k = 0; k < c_nram; k++) begin : g_ram
    assign w_rd[k] = r_line[k][w_col_cur];
    if (k == 0) begin : g_first
      // First line RAM captures the incoming pixel
      always_ff @(posedge clk) begin
        if (w_accept) r_line[k][w_col_cur] <= pixel_in;
      end
    end else begin : g_chain
      // Later line RAMs capture the previous RAM's old value
      always_ff @(posedge clk) begin
        if (w_accept) r_line[k][w_col_cur] <= w_rd[k-1];
      end
    end
  end

  // Newest window column, top (oldest line) to bottom (current pixel)
  always_comb begin
    for (int i = 0; i < WIN; i++) w_newcol[i] = pixel_in;
    for (int i = 0; i < WIN - 1; i++) w_newcol[i] = w_rd[WIN-2-i];
  end

  // Window shift register: shifts one column left per accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++)
        for (int j = 0; j < WIN; j++)
          r_win[i][j] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN - 1; j++)
          r_win[i][j] <= r_win[i][j+1];
        r_win[i][WIN-1] <= w_newcol[i];
      end
    end
  end

  // Pack: top-left element in the MSBs, current pixel in the LSBs
  for (genvar i = 0; i < WIN; i++) begin : g_out_row
    for (genvar j = 0; j < WIN; j++) begin : g_out_col
      assign window_out[((WIN-1-i)*WIN + (WIN-1-j))*DATA_W +: DATA_W] = r_win[i][j];
    end
  end

endmodule
`default_nettype wire
